// File: rtl/csr_file.sv
// Machine-mode CSR register file: mstatus, trap registers, scratch and the 64-bit
// mcycle/minstret counters, with combinational reads for decode and mtvec/mepc for fetch.
module csr_file #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_0100,
  parameter logic [XLEN-1:0] HART_ID  = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_wbk_v_q_i,
  input  logic [11:0]     csr_adr_q_i,
  input  logic [XLEN-1:0] csr_data_q_i,
  input  logic [11:0]     csr_rd_adr_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_rd_illegal_o,
  input  logic            exception_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      core_mode_i,
  input  logic            mret_i,
  input  logic            instret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  logic            st_mie_q, st_mpie_q;
  logic [1:0]      st_mpp_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     mcycle_q, minstret_q, mcycle_d, minstret_d;
  logic [XLEN-1:0] mstatus_rd;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign wr_mstatus   = csr_wbk_v_q_i && (csr_adr_q_i == 12'h300);
  assign wr_mie       = csr_wbk_v_q_i && (csr_adr_q_i == 12'h304);
  assign wr_mtvec     = csr_wbk_v_q_i && (csr_adr_q_i == 12'h305);
  assign wr_mscratch  = csr_wbk_v_q_i && (csr_adr_q_i == 12'h340);
  assign wr_mepc      = csr_wbk_v_q_i && (csr_adr_q_i == 12'h341);
  assign wr_mcause    = csr_wbk_v_q_i && (csr_adr_q_i == 12'h342);
  assign wr_mtval     = csr_wbk_v_q_i && (csr_adr_q_i == 12'h343);
  assign wr_mcycle    = csr_wbk_v_q_i && (csr_adr_q_i == 12'hB00);
  assign wr_mcycleh   = csr_wbk_v_q_i && (csr_adr_q_i == 12'hB80);
  assign wr_minstret  = csr_wbk_v_q_i && (csr_adr_q_i == 12'hB02);
  assign wr_minstreth = csr_wbk_v_q_i && (csr_adr_q_i == 12'hB82);

  // Increment the full 64-bit value first so the carry comes from the pre-write low half,
  // then let a software write overwrite just the addressed half.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (wr_mcycle)  mcycle_d[31:0]  = csr_data_q_i;
    if (wr_mcycleh) mcycle_d[63:32] = csr_data_q_i;
    minstret_d = minstret_q + {63'd0, instret_i};
    if (wr_minstret)  minstret_d[31:0]  = csr_data_q_i;
    if (wr_minstreth) minstret_d[63:32] = csr_data_q_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (wr_mie)      mie_q      <= csr_data_q_i;
      if (wr_mtvec)    mtvec_q    <= {csr_data_q_i[XLEN-1:2], 2'b00};
      if (wr_mscratch) mscratch_q <= csr_data_q_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      st_mpp_q  <= 2'b11;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
    end else if (exception_i) begin
      mepc_q    <= {pc_i[XLEN-1:2], 2'b00};
      mcause_q  <= cause_i;
      mtval_q   <= mtval_i;
      st_mpie_q <= st_mie_q;
      st_mie_q  <= 1'b0;
      st_mpp_q  <= core_mode_i;
    end else begin
      if (mret_i) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
        st_mpp_q  <= 2'b00;
      end else if (wr_mstatus) begin
        st_mie_q  <= csr_data_q_i[3];
        st_mpie_q <= csr_data_q_i[7];
        st_mpp_q  <= csr_data_q_i[12:11];
      end
      if (wr_mepc)   mepc_q   <= {csr_data_q_i[XLEN-1:2], 2'b00};
      if (wr_mcause) mcause_q <= csr_data_q_i;
      if (wr_mtval)  mtval_q  <= csr_data_q_i;
    end
  end

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[3]     = st_mie_q;
    mstatus_rd[7]     = st_mpie_q;
    mstatus_rd[12:11] = st_mpp_q;
  end

  always_comb begin
    csr_rd_data_o    = '0;
    csr_rd_illegal_o = 1'b0;
    case (csr_rd_adr_i)
      12'h300: csr_rd_data_o = mstatus_rd;
      12'h301: csr_rd_data_o = MISA_VAL;
      12'h304: csr_rd_data_o = mie_q;
      12'h305: csr_rd_data_o = mtvec_q;
      12'h340: csr_rd_data_o = mscratch_q;
      12'h341: csr_rd_data_o = mepc_q;
      12'h342: csr_rd_data_o = mcause_q;
      12'h343: csr_rd_data_o = mtval_q;
      12'h344: csr_rd_data_o = '0;
      12'hB00, 12'hC00: csr_rd_data_o = mcycle_q[31:0];
      12'hB80, 12'hC80: csr_rd_data_o = mcycle_q[63:32];
      12'hB02, 12'hC02: csr_rd_data_o = minstret_q[31:0];
      12'hB82, 12'hC82: csr_rd_data_o = minstret_q[63:32];
      12'hF14: csr_rd_data_o = HART_ID;
      default: csr_rd_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = st_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed table, hand-written trap/counter sequences, and random
// traffic checked against an address-indexed reference model.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        csr_wbk_v_q_i = 1'b0;
  logic [11:0] csr_adr_q_i = '0;
  logic [31:0] csr_data_q_i = '0;
  logic [11:0] csr_rd_adr_i = '0;
  logic [31:0] csr_rd_data_o;
  logic        csr_rd_illegal_o;
  logic        exception_i = 1'b0;
  logic [31:0] cause_i = '0;
  logic [31:0] mtval_i = '0;
  logic [31:0] pc_i = '0;
  logic [1:0]  core_mode_i = '0;
  logic        mret_i = 1'b0;
  logic        instret_i = 1'b0;
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_o;

  csr_file dut (
    .clk(clk), .reset_n(reset_n),
    .csr_wbk_v_q_i(csr_wbk_v_q_i), .csr_adr_q_i(csr_adr_q_i), .csr_data_q_i(csr_data_q_i),
    .csr_rd_adr_i(csr_rd_adr_i), .csr_rd_data_o(csr_rd_data_o), .csr_rd_illegal_o(csr_rd_illegal_o),
    .exception_i(exception_i), .cause_i(cause_i), .mtval_i(mtval_i), .pc_i(pc_i),
    .core_mode_i(core_mode_i), .mret_i(mret_i), .instret_i(instret_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: architectural value of each writable CSR, plus the counters as 64-bit numbers.
  bit [31:0] m_csr [int];
  bit [63:0] m_cyc, m_ret;

  function automatic void model_reset();
    m_csr.delete();
    m_csr['h300] = 32'h0000_1800;
    m_csr['h304] = 0; m_csr['h305] = 0; m_csr['h340] = 0;
    m_csr['h341] = 0; m_csr['h342] = 0; m_csr['h343] = 0;
    m_cyc = 0;
    m_ret = 0;
  endfunction

  function automatic bit [31:0] wmask(input int a);
    case (a)
      'h300:        return 32'h0000_1888;
      'h305, 'h341: return 32'hFFFF_FFFC;
      default:      return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic void model_step();
    bit [31:0] old_ms = m_csr['h300];
    bit [63:0] cyc = m_cyc + 64'd1;
    bit [63:0] ret = m_ret + (instret_i ? 64'd1 : 64'd0);
    int a = int'(csr_adr_q_i);
    if (csr_wbk_v_q_i) begin
      if (m_csr.exists(a)) m_csr[a] = csr_data_q_i & wmask(a);
      case (a)
        'hB00: cyc[31:0]  = csr_data_q_i;
        'hB80: cyc[63:32] = csr_data_q_i;
        'hB02: ret[31:0]  = csr_data_q_i;
        'hB82: ret[63:32] = csr_data_q_i;
        default: ;
      endcase
    end
    if (exception_i) begin
      m_csr['h341] = pc_i & 32'hFFFF_FFFC;
      m_csr['h342] = cause_i;
      m_csr['h343] = mtval_i;
      m_csr['h300] = {19'b0, core_mode_i, 3'b0, old_ms[3], 3'b0, 1'b0, 3'b0};
    end else if (mret_i) begin
      m_csr['h300] = {19'b0, 2'b00, 3'b0, 1'b1, 3'b0, old_ms[7], 3'b0};
    end
    m_cyc = cyc;
    m_ret = ret;
  endfunction

  function automatic void model_read(input int a, output bit [31:0] d, output bit ill);
    d = 0;
    ill = 0;
    if (m_csr.exists(a)) d = m_csr[a];
    else case (a)
      'h301:         d = 32'h4000_0100;
      'h344, 'hF14:  d = 0;
      'hB00, 'hC00:  d = m_cyc[31:0];
      'hB80, 'hC80:  d = m_cyc[63:32];
      'hB02, 'hC02:  d = m_ret[31:0];
      'hB82, 'hC82:  d = m_ret[63:32];
      default:       ill = 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    csr_wbk_v_q_i = 1'b1;
    csr_adr_q_i   = 12'(a);
    csr_data_q_i  = d;
  endtask

  task automatic rd_chk(input int a, input logic [31:0] exp, input logic exp_ill);
    csr_rd_adr_i = 12'(a);
    #1;
    chk($sformatf("rd_%03h", a), csr_rd_data_o, exp);
    chk($sformatf("ill_%03h", a), {31'b0, csr_rd_illegal_o}, {31'b0, exp_ill});
  endtask

  task automatic model_chk(input int a);
    bit [31:0] d;
    bit ill;
    model_read(a, d, ill);
    rd_chk(a, d, ill);
  endtask

  typedef struct {
    int          wadr;
    logic [31:0] wdat;
    int          radr;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  int   addr_list[$] = '{'h300, 'h301, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344,
                         'hB00, 'hB80, 'hB02, 'hB82, 'hC00, 'hC80, 'hC02, 'hC82, 'hF14,
                         'h7C0, 'h001, 'hB01};

  initial begin
    model_reset();
    #2;
    chk("rst_mtvec_o", mtvec_o, 32'h0);
    chk("rst_mepc_o", mepc_o, 32'h0);
    chk("rst_mie_o", {31'b0, mie_o}, 32'h0);
    #5 reset_n = 1'b1;
    rd_chk('h300, 32'h0000_1800, 1'b0);
    rd_chk('hF14, 32'h0, 1'b0);
    rd_chk('h7C0, 32'h0, 1'b1);

    tbl.push_back('{'h305, 32'h8000_0103, 'h305, 32'h8000_0100, 1'b0});
    tbl.push_back('{'h340, 32'hA5A5_5A5A, 'h340, 32'hA5A5_5A5A, 1'b0});
    tbl.push_back('{'h341, 32'h0000_1237, 'h341, 32'h0000_1234, 1'b0});
    tbl.push_back('{'h342, 32'h8000_000B, 'h342, 32'h8000_000B, 1'b0});
    tbl.push_back('{'h343, 32'hCAFE_F00D, 'h343, 32'hCAFE_F00D, 1'b0});
    tbl.push_back('{'h304, 32'hFFFF_FFFF, 'h304, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{'h344, 32'hFFFF_FFFF, 'h344, 32'h0, 1'b0});
    tbl.push_back('{'h301, 32'h0, 'h301, 32'h4000_0100, 1'b0});
    tbl.push_back('{'h300, 32'hFFFF_FFFF, 'h300, 32'h0000_1888, 1'b0});
    tbl.push_back('{'hF14, 32'h1, 'hF14, 32'h0, 1'b0});
    tbl.push_back('{'h7C0, 32'h1, 'h7C0, 32'h0, 1'b1});
    tbl.push_back('{'h300, 32'h0000_0008, 'h300, 32'h0000_0008, 1'b0});

    foreach (tbl[i]) begin
      wr(tbl[i].wadr, tbl[i].wdat);
      tick();
      csr_wbk_v_q_i = 1'b0;
      rd_chk(tbl[i].radr, tbl[i].exp, tbl[i].ill);
    end
    chk("mtvec_o", mtvec_o, 32'h8000_0100);
    chk("mepc_o", mepc_o, 32'h0000_1234);
    chk("mie_o", {31'b0, mie_o}, 32'h1);

    // trap then mret
    exception_i = 1'b1; pc_i = 32'h206; cause_i = 32'd2; mtval_i = 32'hDEAD; core_mode_i = 2'd0;
    tick();
    exception_i = 1'b0;
    rd_chk('h341, 32'h204, 1'b0);
    rd_chk('h342, 32'h2, 1'b0);
    rd_chk('h343, 32'hDEAD, 1'b0);
    rd_chk('h300, 32'h80, 1'b0);
    chk("trap_mepc_o", mepc_o, 32'h204);
    chk("trap_mie_o", {31'b0, mie_o}, 32'h0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    rd_chk('h300, 32'h88, 1'b0);
    chk("mret_mie_o", {31'b0, mie_o}, 32'h1);

    // trap beats a same-cycle mcause write
    exception_i = 1'b1; cause_i = 32'd11; wr('h342, 32'd5);
    tick();
    exception_i = 1'b0; csr_wbk_v_q_i = 1'b0;
    rd_chk('h342, 32'd11, 1'b0);
    rd_chk('h300, 32'h80, 1'b0);

    // a write to an unrelated CSR alongside a trap still lands
    exception_i = 1'b1; cause_i = 32'd7; pc_i = 32'h1000; core_mode_i = 2'd3; wr('h340, 32'h55);
    tick();
    exception_i = 1'b0; csr_wbk_v_q_i = 1'b0;
    rd_chk('h340, 32'h55, 1'b0);
    rd_chk('h342, 32'd7, 1'b0);
    rd_chk('h300, 32'h1800, 1'b0);
    chk("trap2_mepc_o", mepc_o, 32'h1000);

    // mret beats a same-cycle mstatus write
    mret_i = 1'b1; wr('h300, 32'h8);
    tick();
    mret_i = 1'b0; csr_wbk_v_q_i = 1'b0;
    rd_chk('h300, 32'h80, 1'b0);

    // mcycle carry into high half
    wr('hB80, 32'h0);
    tick();
    wr('hB00, 32'hFFFF_FFFF);
    tick();
    csr_wbk_v_q_i = 1'b0;
    rd_chk('hB00, 32'hFFFF_FFFF, 1'b0);
    rd_chk('hB80, 32'h0, 1'b0);
    tick();
    rd_chk('hB00, 32'h0, 1'b0);
    rd_chk('hB80, 32'h1, 1'b0);
    rd_chk('hC80, 32'h1, 1'b0);
    wr('hC00, 32'h1234);
    tick();
    csr_wbk_v_q_i = 1'b0;
    rd_chk('hC00, 32'h1, 1'b0);

    // minstret write on the middle of three retire pulses
    instret_i = 1'b1;
    tick();
    wr('hB02, 32'd10);
    tick();
    csr_wbk_v_q_i = 1'b0;
    tick();
    instret_i = 1'b0;
    rd_chk('hB02, 32'd11, 1'b0);
    rd_chk('hB82, 32'd0, 1'b0);
    rd_chk('hC02, 32'd11, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      csr_wbk_v_q_i = ($urandom_range(0, 1) == 1);
      csr_adr_q_i   = 12'(addr_list[$urandom_range(0, addr_list.size() - 1)]);
      csr_data_q_i  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      exception_i   = ($urandom_range(0, 7) == 0);
      mret_i        = ($urandom_range(0, 7) == 0);
      instret_i     = ($urandom_range(0, 1) == 1);
      cause_i       = $urandom;
      mtval_i       = $urandom;
      pc_i          = $urandom;
      core_mode_i   = 2'($urandom_range(0, 3));
      model_chk(addr_list[$urandom_range(0, addr_list.size() - 1)]);
      chk("rnd_mtvec_o", mtvec_o, m_csr['h305]);
      chk("rnd_mepc_o", mepc_o, m_csr['h341]);
      chk("rnd_mie_o", {31'b0, mie_o}, {31'b0, m_csr['h300][3]});
      tick();
    end
    csr_wbk_v_q_i = 1'b0; exception_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;

    // reset mid-operation with a write pending
    wr('h305, 32'hFFFF_FFF0);
    reset_n = 1'b0;
    #1;
    chk("mrst_mtvec_o", mtvec_o, 32'h0);
    chk("mrst_mepc_o", mepc_o, 32'h0);
    chk("mrst_mie_o", {31'b0, mie_o}, 32'h0);
    rd_chk('h300, 32'h1800, 1'b0);
    model_reset();
    csr_wbk_v_q_i = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    rd_chk('hB00, 32'h1, 1'b0);
    model_chk('hB80);
    chk("post_rst_mtvec_o", mtvec_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file. Sits directly downstream of the execute stage.
- Consumes the flopped CSR writeback (valid/address/data), the trap and mret events, and the retire pulse.
- Serves combinational CSR reads to decode, and provides mtvec/mepc to fetch for redirect after trap or mret.
- Holds mstatus, trap registers, scratch, and the 64-bit mcycle/minstret counters.

Parameters:
- XLEN, 32, data width (from riscv_pkg).
- MISA_VAL, 32'h4000_0100, read-only misa value (RV32I).
- HART_ID, 0, read-only mhartid value.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- csr_wbk_v_q_i  input  1  CSR write valid from execute
- csr_adr_q_i  input  12  CSR write address
- csr_data_q_i  input  XLEN  CSR write data
- csr_rd_adr_i  input  12  decode read address
- csr_rd_data_o  output  XLEN  read data (combinational)
- csr_rd_illegal_o  output  1  read address unimplemented
- exception_i  input  1  trap taken this cycle
- cause_i  input  XLEN  mcause value for the trap
- mtval_i  input  XLEN  mtval value for the trap
- pc_i  input  XLEN  faulting instruction PC
- core_mode_i  input  2  current privilege mode
- mret_i  input  1  mret executed
- instret_i  input  1  one instruction retired this cycle
- mtvec_o  output  XLEN  trap vector base
- mepc_o  output  XLEN  return PC
- mie_o  output  1  mstatus.MIE

Behaviour:
- Async reset (reset_n low) clears every register to 0 except mstatus.MPP, which resets to 2'b11.
  - After reset: mtvec_o=0, mepc_o=0, mie_o=0.
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11]; all other bits read 0.
  - misa 0x301: read-only MISA_VAL.
  - mie 0x304: full read/write.
  - mtvec 0x305: bits[1:0] forced 0 (direct mode only).
  - mscratch 0x340: full read/write.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342, mtval 0x343: full read/write.
  - mip 0x344: reads 0, writes ignored.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: read/write.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only shadows of the machine counters.
  - mhartid 0xF14: read-only HART_ID.
- Reads:
  - Combinational from current flop values; no bypass of a same-cycle write.
  - Execute forwards CSR data itself.
  - Unimplemented address: csr_rd_illegal_o=1, csr_rd_data_o=0.
- Writes take effect on the clock edge after csr_wbk_v_q_i=1. Writes to read-only or unimplemented addresses are silently dropped.
- Trap (exception_i=1), applied on the clock edge:
  - mepc <= {pc_i[XLEN-1:2],2'b00}
  - mcause <= cause_i
  - mtval <= mtval_i
  - MPIE <= MIE, MIE <= 0, MPP <= core_mode_i
- mret (mret_i=1, exception_i=0): MIE <= MPIE, MPIE <= 1, MPP <= 2'b00.
- Priority per register: exception_i > mret_i > software write. A software write to mepc, mcause, mtval or mstatus that coincides with a trap is discarded. Writes to other CSRs in the same cycle still occur.
- mcycle:
  - Increments by 1 every cycle, 64-bit, wraps from 2^64-1 to 0.
  - A write to mcycle replaces the low half and the write value is stored as-is (no +1 that cycle); high half increments normally, including carry out of the old low half. Same rule for mcycleh (replaces high half; low half increments).
- minstret: same rules, increments only when instret_i=1.
- Low-to-high carry is computed on the pre-write value within the same cycle.
- mtvec_o, mepc_o and mie_o are direct flop outputs: 0-cycle latency after the update edge.
- Reset mid-operation: all state returns to reset values immediately; pending writes are lost.

Test Plan:
- Reset, then read 0x300 -> 0x0000_1800. Read 0xF14 -> 0. Read 0x7C0 -> illegal=1, data=0.
- Write mtvec 0x8000_0103 -> read 0x8000_0100, mtvec_o=0x8000_0100 the next cycle.
- Set MIE=1, then exception_i with pc_i=0x0000_0206, cause_i=2, mtval_i=0xDEAD, core_mode_i=0 -> mepc=0x204, mcause=2, mtval=0xDEAD, mstatus=0x0000_0080. Then mret_i -> mstatus=0x0000_0088.
- Same-cycle exception_i (cause 11) and CSR write of mcause=5 -> mcause=11.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 on consecutive cycles -> next read of {mcycleh,mcycle}=0x0000_0001_0000_00xx with correct carry. Write 0xC00 -> ignored.
- Pulse instret_i 3 times with a write minstret=10 on the middle pulse -> minstret=11.
